// File: rtl/stack_sequencer_pkg.sv
// Shared types and mask layout for the stack sequencer.
// Mask bit i selects register/item index i.
package stack_sequencer_pkg;

    typedef enum logic {
        STACK_POP  = 1'b0,
        STACK_PUSH = 1'b1
    } stack_dir_e;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_XFER = 2'd1,
        SEQ_DONE = 2'd2
    } stack_seq_state_e;

    localparam int STACK_SP_BIT = 4;

    localparam logic [15:0] STACK_AX     = 16'h0001;
    localparam logic [15:0] STACK_CX     = 16'h0002;
    localparam logic [15:0] STACK_DX     = 16'h0004;
    localparam logic [15:0] STACK_BX     = 16'h0008;
    localparam logic [15:0] STACK_SP     = 16'h0010;
    localparam logic [15:0] STACK_BP     = 16'h0020;
    localparam logic [15:0] STACK_SI     = 16'h0040;
    localparam logic [15:0] STACK_DI     = 16'h0080;
    localparam logic [15:0] STACK_ES     = 16'h0100;
    localparam logic [15:0] STACK_CS     = 16'h0200;
    localparam logic [15:0] STACK_SS     = 16'h0400;
    localparam logic [15:0] STACK_DS     = 16'h0800;
    localparam logic [15:0] STACK_FLAGS  = 16'h1000;
    localparam logic [15:0] STACK_ALL_GP = 16'h00FF;

endpackage

// File: rtl/stack_sequencer_prio_enc.sv
// Lowest/highest set-bit encoder used to pick the next stack item.
module mask_prio_enc #(
    parameter int MASK_W = 16,
    parameter int IDX_W  = $clog2(MASK_W)
) (
    input  logic [MASK_W-1:0] mask,
    output logic [IDX_W-1:0]  lo_idx,
    output logic [IDX_W-1:0]  hi_idx,
    output logic              any_set
);

    always_comb begin
        lo_idx = '0;
        hi_idx = '0;
        for (int i = MASK_W - 1; i >= 0; i--) begin
            if (mask[i]) lo_idx = IDX_W'(i);
        end
        for (int i = 0; i < MASK_W; i++) begin
            if (mask[i]) hi_idx = IDX_W'(i);
        end
    end

    assign any_set = |mask;

endmodule

// File: rtl/stack_sequencer.sv
// Walks a push/pop register mask and issues one stack access per set bit.
// Addresses are SS offsets; the BIU adds the segment base.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// SEQ_IDLE | waiting for start; captures mask, direction and SP
// SEQ_XFER | one access in flight per cycle group, held until mem_ack
// SEQ_DONE | one-cycle done pulse, final SP valid on sp_out
module stack_sequencer
    import stack_sequencer_pkg::*;
#(
    parameter int MASK_W = 16,
    parameter int IDX_W  = 4,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int SP_BIT = STACK_SP_BIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              start_push,
    input  logic [MASK_W-1:0] start_mask,
    input  logic [ADDR_W-1:0] sp_in,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] sp_out,
    output logic [IDX_W-1:0]  rd_index,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_en,
    output logic [IDX_W-1:0]  wr_index,
    output logic [DATA_W-1:0] wr_data,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(DATA_W / 8);

    stack_seq_state_e  state_q, state_d;
    stack_dir_e        dir_q, dir_d;
    logic [MASK_W-1:0] mask_q, mask_d;
    logic [ADDR_W-1:0] sp_q, sp_d;
    logic [ADDR_W-1:0] sp_orig_q, sp_orig_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [IDX_W-1:0]  lo_idx, hi_idx, item;
    logic              any_set, in_xfer, is_push, is_sp_item;
    logic [MASK_W-1:0] mask_rem;

    mask_prio_enc #(
        .MASK_W (MASK_W),
        .IDX_W  (IDX_W)
    ) u_prio_enc (
        .mask    (mask_q),
        .lo_idx  (lo_idx),
        .hi_idx  (hi_idx),
        .any_set (any_set)
    );

    // Push stores low registers first; pop restores in the mirrored order.
    assign is_push    = (dir_q == STACK_PUSH);
    assign item       = is_push ? lo_idx : hi_idx;
    assign is_sp_item = (item == IDX_W'(SP_BIT));
    assign in_xfer    = (state_q == SEQ_XFER) && any_set;
    assign mask_rem   = mask_q & ~(MASK_W'(1) << item);

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        mask_d    = mask_q;
        sp_d      = sp_q;
        sp_orig_d = sp_orig_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            SEQ_IDLE: begin
                if (start) begin
                    dir_d     = start_push ? STACK_PUSH : STACK_POP;
                    mask_d    = start_mask;
                    sp_d      = sp_in;
                    sp_orig_d = sp_in;
                    busy_d    = 1'b1;
                    if (|start_mask) begin
                        state_d = SEQ_XFER;
                    end else begin
                        state_d = SEQ_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            SEQ_XFER: begin
                if (!any_set) begin
                    state_d = SEQ_DONE;
                    done_d  = 1'b1;
                end else if (mem_ack) begin
                    sp_d   = is_push ? (sp_q - STEP) : (sp_q + STEP);
                    mask_d = mask_rem;
                    if (mask_rem == '0) begin
                        state_d = SEQ_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            SEQ_DONE: begin
                state_d = SEQ_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = SEQ_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= SEQ_IDLE;
            dir_q     <= STACK_POP;
            mask_q    <= '0;
            sp_q      <= '0;
            sp_orig_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            mask_q    <= mask_d;
            sp_q      <= sp_d;
            sp_orig_q <= sp_orig_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign sp_out    = sp_q;
    assign rd_index  = item;
    assign mem_req   = in_xfer;
    assign mem_wr    = is_push;
    assign mem_addr  = is_push ? (sp_q - STEP) : sp_q;
    // The SP slot carries the pre-sequence SP, not the register file copy.
    assign mem_wdata = is_sp_item ? DATA_W'(sp_orig_q) : rd_data;
    assign wr_en     = in_xfer && mem_ack && !is_push && !is_sp_item;
    assign wr_index  = item;
    assign wr_data   = mem_rdata;

endmodule

// File: tb/tb_stack_sequencer.sv
// Self-checking bench for stack_sequencer: access-list model plus directed cases.
module tb_stack_sequencer;

    typedef struct {
        logic [15:0] addr;
        logic        wr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        logic        has_wr;
        logic [3:0]  widx;
    } acc_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, start_push;
    logic [15:0] start_mask, sp_in;
    logic        busy, done;
    logic [15:0] sp_out;
    logic [3:0]  rd_index;
    logic [15:0] rd_data;
    logic        wr_en;
    logic [3:0]  wr_index;
    logic [15:0] wr_data;
    logic        mem_req, mem_wr;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    logic [15:0] rf [16];
    logic [15:0] rd_vals [16];
    acc_t        expq [$];
    acc_t        obs [$];
    logic [15:0] exp_sp, sp_at_done;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          t_start = 0;
    int          exp_done_cyc = 0;
    int          n_items = 0;
    int          ack_wait = 0;
    int          wcnt = 0;
    bit          active = 0;
    bit          seq_done = 0;

    always #5 clk = ~clk;

    assign rd_data = rf[rd_index];

    stack_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_push (start_push),
        .start_mask (start_mask),
        .sp_in      (sp_in),
        .busy       (busy),
        .done       (done),
        .sp_out     (sp_out),
        .rd_index   (rd_index),
        .rd_data    (rd_data),
        .wr_en      (wr_en),
        .wr_index   (wr_index),
        .wr_data    (wr_data),
        .mem_req    (mem_req),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: the ordered list of stack accesses a mask implies, and the final SP.
    task automatic build(input logic push, input logic [15:0] mask, input logic [15:0] sp);
        logic [15:0] s;
        acc_t e;
        int k;
        s = sp;
        k = 0;
        expq.delete();
        if (push) begin
            for (int i = 0; i < 16; i++) begin
                if (mask[i]) begin
                    s = s - 16'd2;
                    e.addr = s; e.wr = 1'b1;
                    e.wdata = (i == 4) ? sp : rf[i];
                    e.rdata = 16'h0; e.has_wr = 1'b0; e.widx = 4'(i);
                    expq.push_back(e);
                end
            end
        end else begin
            for (int i = 15; i >= 0; i--) begin
                if (mask[i]) begin
                    e.addr = s; e.wr = 1'b0; e.wdata = 16'h0;
                    e.rdata = rd_vals[k]; e.has_wr = (i != 4); e.widx = 4'(i);
                    expq.push_back(e);
                    s = s + 16'd2;
                    k++;
                end
            end
        end
        exp_sp  = s;
        n_items = expq.size();
    endtask

    // Compare process: memory side, register writes and the done pulse every cycle.
    always @(negedge clk) begin
        acc_t o;
        cyc++;
        if (reset) begin
            mem_ack   = 1'b0;
            mem_rdata = 16'h0;
            wcnt      = 0;
        end else begin
            mem_ack = 1'b0;
            if (mem_req) begin
                if (expq.size() == 0) begin
                    chk("spurious_mem_req", {31'd0, mem_req}, 32'd0);
                end else begin
                    chk("mem_addr", {16'd0, mem_addr}, {16'd0, expq[0].addr});
                    chk("mem_wr", {31'd0, mem_wr}, {31'd0, expq[0].wr});
                    if (expq[0].wr) chk("mem_wdata", {16'd0, mem_wdata}, {16'd0, expq[0].wdata});
                    if (wcnt == ack_wait) begin
                        mem_ack   = 1'b1;
                        mem_rdata = expq[0].rdata;
                    end else begin
                        mem_rdata = 16'hDEAD;
                        wcnt++;
                    end
                end
            end
            #1;
            if (mem_ack && expq.size() > 0) begin
                chk("wr_en", {31'd0, wr_en}, {31'd0, expq[0].has_wr});
                if (expq[0].has_wr) begin
                    chk("wr_index", {28'd0, wr_index}, {28'd0, expq[0].widx});
                    chk("wr_data", {16'd0, wr_data}, {16'd0, expq[0].rdata});
                end
                o.addr = mem_addr; o.wr = mem_wr;
                o.wdata = mem_wr ? mem_wdata : wr_data;
                o.rdata = mem_rdata; o.has_wr = wr_en; o.widx = wr_index;
                obs.push_back(o);
                void'(expq.pop_front());
                wcnt = 0;
            end else begin
                chk("wr_en_idle", {31'd0, wr_en}, 32'd0);
            end
            if (done) begin
                if (!active) begin
                    chk("spurious_done", {31'd0, done}, 32'd0);
                end else begin
                    chk("done_cycle", cyc - t_start, exp_done_cyc - t_start);
                    chk("sp_out_done", {16'd0, sp_out}, {16'd0, exp_sp});
                    chk("items_left", expq.size(), 32'd0);
                    chk("busy_in_done", {31'd0, busy}, 32'd1);
                    sp_at_done = sp_out;
                    active     = 0;
                    seq_done   = 1;
                end
            end
        end
    end

    task automatic run(input logic push, input logic [15:0] mask, input logic [15:0] sp,
                       input int w, input int hold);
        build(push, mask, sp);
        obs.delete();
        ack_wait = w;
        @(negedge clk); #2;
        start = 1'b1; start_push = push; start_mask = mask; sp_in = sp;
        t_start = cyc;
        exp_done_cyc = t_start + 1 + n_items * (w + 1);
        seq_done = 0;
        active = 1;
        // Extra start cycles land while busy or in DONE and must be ignored.
        for (int i = 0; i < hold; i++) begin
            @(negedge clk); #2;
            start_push = ~push; start_mask = 16'hFFFF; sp_in = 16'h5555;
        end
        @(negedge clk); #2;
        start = 1'b0;
        for (int i = 0; i < 300 && !seq_done; i++) begin
            @(negedge clk); #2;
        end
        chk("done_seen", {31'd0, seq_done}, 32'd1);
        repeat (3) @(negedge clk);
        #2;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = 16'hA0A0 + 16'(i);
        rf[0] = 16'h1234;
        rf[1] = 16'h5678;
        for (int i = 0; i < 16; i++) rd_vals[i] = 16'hC000 + 16'(i);
        reset = 1'b1; start = 1'b0; start_push = 1'b0;
        start_mask = 16'h0; sp_in = 16'h0;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_sp_out", {16'd0, sp_out}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
        reset = 1'b0;

        // push AX,CX with start held through busy and the done cycle
        run(1'b1, 16'h0003, 16'h0100, 0, 3);
        chk("p2_n", obs.size(), 32'd2);
        if (obs.size() == 2) begin
            chk("p2_addr0", {16'd0, obs[0].addr}, 32'h00FE);
            chk("p2_data0", {16'd0, obs[0].wdata}, 32'h1234);
            chk("p2_addr1", {16'd0, obs[1].addr}, 32'h00FC);
            chk("p2_data1", {16'd0, obs[1].wdata}, 32'h5678);
        end
        chk("p2_sp", {16'd0, sp_at_done}, 32'h00FC);
        chk("p2_done_lat", exp_done_cyc - t_start, 32'd3);

        // pop SP,AX: SP slot is read and discarded
        rd_vals[0] = 16'hAAAA;
        rd_vals[1] = 16'hBBBB;
        run(1'b0, 16'h0011, 16'h00F0, 0, 0);
        chk("pop_n", obs.size(), 32'd2);
        if (obs.size() == 2) begin
            chk("pop_addr0", {16'd0, obs[0].addr}, 32'h00F0);
            chk("pop_wr0", {31'd0, obs[0].has_wr}, 32'd0);
            chk("pop_addr1", {16'd0, obs[1].addr}, 32'h00F2);
            chk("pop_wr1", {31'd0, obs[1].has_wr}, 32'd1);
            chk("pop_idx1", {28'd0, obs[1].widx}, 32'd0);
            chk("pop_data1", {16'd0, obs[1].wdata}, 32'hBBBB);
        end
        chk("pop_sp", {16'd0, sp_at_done}, 32'h00F4);

        // full general-purpose push
        run(1'b1, 16'h00FF, 16'h0200, 0, 0);
        chk("p8_n", obs.size(), 32'd8);
        if (obs.size() == 8) begin
            chk("p8_addr0", {16'd0, obs[0].addr}, 32'h01FE);
            chk("p8_addr7", {16'd0, obs[7].addr}, 32'h01F0);
            chk("p8_sp_item", {16'd0, obs[4].wdata}, 32'h0200);
        end
        chk("p8_sp", {16'd0, sp_at_done}, 32'h01F0);

        // SP wrap below zero
        run(1'b1, 16'h0001, 16'h0000, 0, 0);
        if (obs.size() == 1) chk("wrap_addr", {16'd0, obs[0].addr}, 32'hFFFE);
        chk("wrap_sp", {16'd0, sp_at_done}, 32'hFFFE);

        // empty mask, start held into the done cycle
        run(1'b1, 16'h0000, 16'h1234, 0, 1);
        chk("empty_n", obs.size(), 32'd0);
        chk("empty_sp", {16'd0, sp_at_done}, 32'h1234);

        // wait states on every access
        run(1'b1, 16'h0003, 16'h0100, 3, 0);
        chk("ws_sp", {16'd0, sp_at_done}, 32'h00FC);

        // reset during the second item of a wait-state push
        build(1'b1, 16'h0003, 16'h0100);
        obs.delete();
        ack_wait = 3;
        @(negedge clk); #2;
        start = 1'b1; start_push = 1'b1; start_mask = 16'h0003; sp_in = 16'h0100;
        t_start = cyc; active = 1; seq_done = 0;
        exp_done_cyc = t_start + 1 + n_items * 4;
        @(negedge clk); #2;
        start = 1'b0;
        for (int i = 0; i < 50 && cyc < t_start + 6; i++) begin
            @(negedge clk); #2;
        end
        chk("rst_mid_req_before", {31'd0, mem_req}, 32'd1);
        chk("rst_mid_addr_before", {16'd0, mem_addr}, 32'h00FC);
        active = 0;
        expq.delete();
        reset = 1'b1;
        #1;
        chk("rst_mid_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_sp", {16'd0, sp_out}, 32'd0);
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        chk("post_rst_req", {31'd0, mem_req}, 32'd0);
        chk("post_rst_sp", {16'd0, sp_out}, 32'd0);

        // sequencer accepts work again after reset
        run(1'b1, 16'h0001, 16'h0010, 0, 0);
        chk("post_rst_run_sp", {16'd0, sp_at_done}, 32'h000E);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
